divider: RTL and testbench

- Iterative unsigned restoring divider; the inverse operation of the team's sequential multiplier.
- Uses the same trigger/ready/done handshake and C_WIDTH/FIXED_POINT parameterisation, so voice/envelope arithmetic can swap it in beside the multiplier.
- Computes quotient and remainder of a C_WIDTH-bit dividend by a C_WIDTH-bit divisor, producing one quotient bit per clock.

---
 rtl/divider.sv | 143 ++++++++++++++
 tb/tb_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Iterative unsigned restoring divider with optional fixed-point scaling; one quotient bit per clock.
// Latency: done high N = C_WIDTH+FIXED_POINT cycles after acceptance (1 cycle when b=0); issue interval N+2.
// Backpressure: trigger is sampled only while ready=1; triggers during CALC/DONE are dropped, not queued.
module divider #(
    parameter int C_WIDTH     = 8,
    parameter int FIXED_POINT = 0
) (
    input  logic               ctl_clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic [C_WIDTH-1:0] a,
    input  logic [C_WIDTH-1:0] b,
    output logic [C_WIDTH-1:0] q,
    output logic [C_WIDTH-1:0] r,
    output logic               ready,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int N  = C_WIDTH + FIXED_POINT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [N-1:0]       r_dvd;   // extended dividend, consumed MSB first
    logic [C_WIDTH-1:0] r_div;   // latched divisor
    logic [C_WIDTH-1:0] r_rem;   // partial remainder, always < r_div
    logic [N-2:0]       r_quo;   // quotient bits collected so far
    logic [CW-1:0]      r_cnt;   // CALC edges remaining
    logic [C_WIDTH-1:0] r_q;
    logic [C_WIDTH-1:0] r_r;
    logic               r_dbz;
    logic               r_ovf;

    logic [C_WIDTH:0]   w_rem_shift;
    logic [C_WIDTH:0]   w_sub;
    logic               w_ge;
    logic [C_WIDTH-1:0] w_rem_nxt;
    logic [N-1:0]       w_quo_nxt;
    logic               w_last;
    logic               w_ovf;

    // One restoring step: since rem < b, the C_WIDTH+1 bit difference's MSB is a true sign bit.
    always_comb begin
        w_rem_shift = {r_rem, r_dvd[N-1]};
        w_sub       = w_rem_shift - {1'b0, r_div};
        w_ge        = ~w_sub[C_WIDTH];
        w_rem_nxt   = w_ge ? w_sub[C_WIDTH-1:0] : w_rem_shift[C_WIDTH-1:0];
        w_quo_nxt   = {r_quo, w_ge};
        w_last      = (r_cnt == CW'(1));
        w_ovf       = ((w_quo_nxt >> C_WIDTH) != '0);
    end

    // State register.
    always_ff @(posedge ctl_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; a zero divisor still passes through a single CALC cycle so done lands one cycle after E1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (trigger) w_state_nxt = S_CALC;
            S_CALC:  if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        ready = (r_state == S_IDLE);
        done  = (r_state == S_DONE);
    end

    // Datapath: operand capture, shift/subtract iterations, result load on the final step.
    always_ff @(posedge ctl_clk) begin
        if (reset) begin
            r_dvd <= '0;
            r_div <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_div <= b;
                        r_rem <= '0;
                        r_quo <= '0;
                        if (b != '0) begin
                            r_dvd <= N'(a) << FIXED_POINT;
                            r_cnt <= CW'(N);
                        end else begin
                            // keep a unscaled: it becomes the remainder directly
                            r_dvd <= N'(a);
                            r_cnt <= CW'(1);
                        end
                    end
                end
                S_CALC: begin
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt[N-2:0];
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        if (r_div == '0) begin
                            r_q   <= '1;
                            r_r   <= r_dvd[C_WIDTH-1:0];
                            r_dbz <= 1'b1;
                            r_ovf <= 1'b0;
                        end else begin
                            r_q   <= w_ovf ? '1 : w_quo_nxt[C_WIDTH-1:0];
                            r_r   <= w_rem_nxt;
                            r_dbz <= 1'b0;
                            r_ovf <= w_ovf;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_divider.sv
// Drives two dividers (FIXED_POINT 0 and 4) with shared stimulus and checks both against an arithmetic model.
// Latency: bench observes each operation over a fixed 16-cycle window after acceptance.
// Backpressure: waits (bounded) for ready on both instances before each new trigger.
module tb_divider;

    localparam int FP [2] = '{0, 4};

    logic            ctl_clk = 1'b0;
    logic            reset;
    logic            trigger;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [1:0][7:0] q_v;
    logic [1:0][7:0] r_v;
    logic [1:0]      rdy_v;
    logic [1:0]      done_v;
    logic [1:0]      dbz_v;
    logic [1:0]      ovf_v;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 ctl_clk = ~ctl_clk;

    divider #(.C_WIDTH(8), .FIXED_POINT(0)) u_fp0 (
        .ctl_clk(ctl_clk), .reset(reset), .trigger(trigger), .a(a), .b(b),
        .q(q_v[0]), .r(r_v[0]), .ready(rdy_v[0]), .done(done_v[0]),
        .div_by_zero(dbz_v[0]), .overflow(ovf_v[0])
    );

    divider #(.C_WIDTH(8), .FIXED_POINT(4)) u_fp4 (
        .ctl_clk(ctl_clk), .reset(reset), .trigger(trigger), .a(a), .b(b),
        .q(q_v[1]), .r(r_v[1]), .ready(rdy_v[1]), .done(done_v[1]),
        .div_by_zero(dbz_v[1]), .overflow(ovf_v[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Reference: plain integer division of the scaled dividend, saturating at 8 bits.
    function automatic void model(input int fp, input int av, input int bv,
                                  output int eq, output int er, output int edz, output int eov);
        int d;
        d = av << fp;
        if (bv == 0) begin
            eq = 255; er = av; edz = 1; eov = 0;
        end else begin
            eq = d / bv; er = d % bv; edz = 0; eov = 0;
            if (eq > 255) begin
                eq = 255; eov = 1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    // One operation on both instances; optional mid-CALC retrigger with different operands.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit retrig);
        int w;
        int lat [2];
        int pulses [2];
        int cq [2];
        int cr [2];
        int cd [2];
        int co [2];
        int eq, er, edz, eov;
        w = 0;
        while (rdy_v != 2'b11 && w < 30) begin
            tick();
            w++;
        end
        chk("ready_wait", rdy_v, 3);
        for (int i = 0; i < 2; i++) begin
            lat[i] = -1; pulses[i] = 0; cq[i] = -1; cr[i] = -1; cd[i] = -1; co[i] = -1;
        end
        a = av; b = bv; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int i = 0; i < 2; i++) chk($sformatf("fp%0d_ready_low", FP[i]), rdy_v[i], 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (retrig && k == 3) begin
                a = 8'($urandom); b = 8'($urandom_range(1, 255)); trigger = 1'b1;
            end
            if (retrig && k == 4) trigger = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (done_v[i]) begin
                    pulses[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = k; cq[i] = q_v[i]; cr[i] = r_v[i]; cd[i] = dbz_v[i]; co[i] = ovf_v[i];
                    end
                end
                if (lat[i] >= 0 && k == lat[i] + 1)
                    chk($sformatf("fp%0d_ready_after", FP[i]), rdy_v[i], 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            model(FP[i], av, bv, eq, er, edz, eov);
            chk($sformatf("fp%0d_latency a=%0h b=%0h", FP[i], av, bv), lat[i], (bv == 0) ? 1 : 8 + FP[i]);
            chk($sformatf("fp%0d_pulses", FP[i]), pulses[i], 1);
            chk($sformatf("fp%0d_q a=%0h b=%0h", FP[i], av, bv), cq[i], eq);
            chk($sformatf("fp%0d_r a=%0h b=%0h", FP[i], av, bv), cr[i], er);
            chk($sformatf("fp%0d_dbz", FP[i]), cd[i], edz);
            chk($sformatf("fp%0d_ovf", FP[i]), co[i], eov);
            chk($sformatf("fp%0d_q_hold", FP[i]), q_v[i], eq);
            chk($sformatf("fp%0d_r_hold", FP[i]), r_v[i], er);
        end
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b0; a = '0; b = '0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("fp%0d_rst_ready", FP[i]), rdy_v[i], 1);
            chk($sformatf("fp%0d_rst_done", FP[i]), done_v[i], 0);
            chk($sformatf("fp%0d_rst_q", FP[i]), q_v[i], 0);
            chk($sformatf("fp%0d_rst_r", FP[i]), r_v[i], 0);
            chk($sformatf("fp%0d_rst_flags", FP[i]), {dbz_v[i], ovf_v[i]}, 0);
        end
        reset = 1'b0;

        // directed cases
        run_op(8'h07, 8'h02, 1'b0);
        run_op(8'h24, 8'h70, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'h10, 8'h20, 1'b0);
        run_op(8'h5A, 8'h00, 1'b0);
        run_op(8'h63, 8'h05, 1'b0);
        run_op(8'h00, 8'h09, 1'b0);
        run_op(8'hB7, 8'h0D, 1'b1);

        // reset during the 4th CALC cycle
        a = 8'h9C; b = 8'h07; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("fp%0d_midrst_ready", FP[i]), rdy_v[i], 1);
            chk($sformatf("fp%0d_midrst_done", FP[i]), done_v[i], 0);
            chk($sformatf("fp%0d_midrst_q", FP[i]), q_v[i], 0);
            chk($sformatf("fp%0d_midrst_r", FP[i]), r_v[i], 0);
        end
        reset = 1'b0;
        run_op(8'hC8, 8'h0A, 1'b0);

        // randomized operands, biased towards small and zero divisors
        for (int n = 0; n < 24; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            run_op(ra, rb, ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
